// File: rtl/shift_engine.sv
// Iterative ARM data-processing shifter: one bit position per cycle for LSL/LSR/ASR/ROR/RRX,
// covering both the immediate-shift and register-shift encodings, under a start/ready/done handshake.
module shift_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] shiftee,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amount,
  input  logic        imm_form,
  input  logic        carry_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] shifter_operand,
  output logic        shifter_carry_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_data;
  logic        r_carry;
  logic [5:0]  r_count;
  logic        r_ready;
  logic        r_done;
  logic [31:0] r_operand;
  logic        r_carry_out;

  op_t         w_op;
  logic [5:0]  w_n;
  logic        w_cin;
  logic [31:0] w_sh_data;
  logic        w_sh_carry;

  // Decode the request into an iteration count and starting carry; the
  // out-of-range cases fall out naturally from shifting N times.
  always_comb begin
    w_op  = OP_LSL;
    w_n   = '0;
    w_cin = carry_in;
    if (imm_form) begin
      unique case (shift_type)
        2'b00: begin
          w_op = OP_LSL;
          w_n  = {1'b0, shift_amount[4:0]};
        end
        2'b01: begin
          w_op = OP_LSR;
          w_n  = (shift_amount[4:0] == 5'd0) ? 6'd32 : {1'b0, shift_amount[4:0]};
        end
        2'b10: begin
          w_op = OP_ASR;
          w_n  = (shift_amount[4:0] == 5'd0) ? 6'd32 : {1'b0, shift_amount[4:0]};
        end
        default: begin
          if (shift_amount[4:0] == 5'd0) begin
            w_op = OP_RRX;
            w_n  = 6'd1;
          end else begin
            w_op = OP_ROR;
            w_n  = {1'b0, shift_amount[4:0]};
          end
        end
      endcase
    end else begin
      unique case (shift_type)
        2'b00: begin
          w_op = OP_LSL;
          w_n  = (shift_amount > 8'd33) ? 6'd33 : shift_amount[5:0];
        end
        2'b01: begin
          w_op = OP_LSR;
          w_n  = (shift_amount > 8'd33) ? 6'd33 : shift_amount[5:0];
        end
        2'b10: begin
          w_op = OP_ASR;
          w_n  = (shift_amount > 8'd32) ? 6'd32 : shift_amount[5:0];
        end
        default: begin
          w_op = OP_ROR;
          w_n  = {1'b0, shift_amount[4:0]};
          // Rotation by a non-zero multiple of 32 leaves data but sets carry to bit31
          if (shift_amount != 8'd0 && shift_amount[4:0] == 5'd0) w_cin = shiftee[31];
        end
      endcase
    end
  end

  always_comb begin
    w_sh_data  = r_data;
    w_sh_carry = r_carry;
    unique case (r_op)
      OP_LSL: begin
        w_sh_data  = {r_data[30:0], 1'b0};
        w_sh_carry = r_data[31];
      end
      OP_LSR: begin
        w_sh_data  = {1'b0, r_data[31:1]};
        w_sh_carry = r_data[0];
      end
      OP_ASR: begin
        w_sh_data  = {r_data[31], r_data[31:1]};
        w_sh_carry = r_data[0];
      end
      OP_ROR: begin
        w_sh_data  = {r_data[0], r_data[31:1]};
        w_sh_carry = r_data[0];
      end
      default: begin
        w_sh_data  = {r_carry, r_data[31:1]};
        w_sh_carry = r_data[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LSL;
      r_data      <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_operand   <= '0;
      r_carry_out <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= w_op;
            r_data  <= shiftee;
            r_carry <= w_cin;
            r_count <= w_n;
            r_ready <= 1'b0;
            if (w_n == 6'd0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_operand   <= shiftee;
              r_carry_out <= w_cin;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data  <= w_sh_data;
          r_carry <= w_sh_carry;
          r_count <= r_count - 6'd1;
          if (r_count == 6'd1) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_operand   <= w_sh_data;
            r_carry_out <= w_sh_carry;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready             = r_ready;
  assign done              = r_done;
  assign shifter_operand   = r_operand;
  assign shifter_carry_out = r_carry_out;

endmodule
